// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU; 1-cycle logic/add/sub/shift, iterative shift-add MUL.
// Optional restoring unsigned DIV/MOD when `define ALU_SEQ_DIVIDE_EN is set.
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    input  logic             cin,
    input  logic             vin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             cout,
    output logic             vout
);

    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_CMP = 6'd2;
    localparam logic [5:0] OP_AND = 6'd3;
    localparam logic [5:0] OP_OR  = 6'd4;
    localparam logic [5:0] OP_XOR = 6'd5;
    localparam logic [5:0] OP_MOV = 6'd6;
    localparam logic [5:0] OP_ASL = 6'd7;
    localparam logic [5:0] OP_ASR = 6'd8;
    localparam logic [5:0] OP_LSR = 6'd9;
    localparam logic [5:0] OP_ROL = 6'd10;
    localparam logic [5:0] OP_ROR = 6'd11;
    localparam logic [5:0] OP_MUL = 6'd12;
    localparam logic [5:0] OP_DIV = 6'd13;
    localparam logic [5:0] OP_MOD = 6'd14;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               cin_q, cin_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               cout_q, cout_d;
    logic               vout_q, vout_d;
`ifdef ALU_SEQ_DIVIDE_EN
    logic               mod_q, mod_d;
`endif

    logic               idle;
    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W:0]   rev;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH:0]     asl_w, lsr_w, asr_w;
    logic [WIDTH:0]     rot_x, rol_w, ror_w;

    logic [WIDTH-1:0]   op_dout;
    logic               op_cout, op_vout;
    logic               op_mul, op_div;

    logic [WIDTH-1:0]   hi_src, lo_src, a_src;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH:0]     mul_sum;

    assign busy  = (state_q == S_MUL) || (state_q == S_DIV);
    assign idle  = !busy;
    assign done  = done_q;
    assign dout  = dout_q;
    assign cout  = cout_q;
    assign vout  = vout_q;

    assign shamt = din_b[SHAMT_W-1:0];
    assign sum   = {1'b0, din_a} + {1'b0, din_b};
    assign diff  = {1'b0, din_a} - {1'b0, din_b};

    // Shifts work on WIDTH+1 bits so the last bit out lands in the carry slot.
    assign asl_w = {1'b0, din_a} << shamt;
    assign lsr_w = {din_a, 1'b0} >> shamt;
    assign asr_w = $unsigned($signed({din_a, 1'b0}) >>> shamt);

    assign rot_x = {cin, din_a};
    assign rev   = (SHAMT_W+1)'(WIDTH+1) - {1'b0, shamt};
    assign rol_w = (rot_x << shamt) | (rot_x >> rev);
    assign ror_w = (rot_x >> shamt) | (rot_x << rev);

    always_comb begin
        op_dout = din_b;
        op_cout = cin;
        op_vout = vin;
        op_mul  = 1'b0;
        op_div  = 1'b0;
        case (opcode)
            OP_ADD: begin
                op_dout = sum[WIDTH-1:0];
                op_cout = sum[WIDTH];
                op_vout = (din_a[WIDTH-1] == din_b[WIDTH-1])
                       && (sum[WIDTH-1] != din_a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                op_dout = diff[WIDTH-1:0];
                op_cout = diff[WIDTH];
                op_vout = (din_a[WIDTH-1] != din_b[WIDTH-1])
                       && (diff[WIDTH-1] != din_a[WIDTH-1]);
            end
            OP_AND: begin
                op_dout = din_a & din_b;
                op_cout = 1'b0;
            end
            OP_OR: begin
                op_dout = din_a | din_b;
                op_cout = 1'b0;
            end
            OP_XOR: begin
                op_dout = din_a ^ din_b;
                op_cout = 1'b0;
            end
            OP_ASL: begin
                op_dout = asl_w[WIDTH-1:0];
                op_cout = (shamt == '0) ? cin : asl_w[WIDTH];
            end
            OP_LSR: begin
                op_dout = lsr_w[WIDTH:1];
                op_cout = (shamt == '0) ? cin : lsr_w[0];
            end
            OP_ASR: begin
                op_dout = asr_w[WIDTH:1];
                op_cout = (shamt == '0) ? cin : asr_w[0];
            end
            OP_ROL: begin
                op_dout = rol_w[WIDTH-1:0];
                op_cout = rol_w[WIDTH];
            end
            OP_ROR: begin
                op_dout = ror_w[WIDTH-1:0];
                op_cout = ror_w[WIDTH];
            end
            OP_MUL: op_mul = 1'b1;
`ifdef ALU_SEQ_DIVIDE_EN
            OP_DIV, OP_MOD: begin
                if (din_b == '0) begin
                    op_dout = (opcode == OP_DIV) ? '1 : din_a;
                    op_vout = 1'b1;
                end else begin
                    op_div = 1'b1;
                end
            end
`else
            OP_MOV, OP_DIV, OP_MOD: ;
`endif
            default: ;
        endcase
    end

    // The accept edge already performs the first iteration from the raw inputs.
    always_comb begin
        if (idle) begin
            hi_src = '0;
            lo_src = op_div ? din_a : din_b;
            a_src  = op_div ? din_b : din_a;
        end else begin
            hi_src = hi_q;
            lo_src = lo_q;
            a_src  = a_q;
        end
    end

`ifdef ALU_SEQ_DIVIDE_EN
    logic             step_div;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] r_sub;
    logic             r_ge;

    assign step_div = idle ? op_div : (state_q == S_DIV);
    assign r_sh     = {hi_src, lo_src[WIDTH-1]};
    assign r_ge     = r_sh >= {1'b0, a_src};
    assign r_sub    = r_sh[WIDTH-1:0] - a_src;
`endif

    always_comb begin
        mul_sum = {1'b0, hi_src} + (lo_src[0] ? {1'b0, a_src} : '0);
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo_src[WIDTH-1:1]};
`ifdef ALU_SEQ_DIVIDE_EN
        if (step_div) begin
            step_hi = r_ge ? r_sub : r_sh[WIDTH-1:0];
            step_lo = {lo_src[WIDTH-2:0], r_ge};
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        cin_d   = cin_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        cout_d  = cout_q;
        vout_d  = vout_q;
`ifdef ALU_SEQ_DIVIDE_EN
        mod_d   = mod_q;
`endif
        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start) begin
                    if (op_mul || op_div) begin
                        state_d = op_mul ? S_MUL : S_DIV;
                        hi_d    = step_hi;
                        lo_d    = step_lo;
                        a_d     = a_src;
                        cnt_d   = SHAMT_W'(1);
                        cin_d   = cin;
`ifdef ALU_SEQ_DIVIDE_EN
                        mod_d   = (opcode == OP_MOD);
`endif
                    end else begin
                        done_d = 1'b1;
                        dout_d = op_dout;
                        cout_d = op_cout;
                        vout_d = op_vout;
                    end
                end
            end
            default: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(WIDTH-1)) begin
                    state_d = S_FIN;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    cout_d  = cin_q;
                    dout_d  = step_lo;
                    vout_d  = |step_hi;
`ifdef ALU_SEQ_DIVIDE_EN
                    if (state_q == S_DIV) begin
                        dout_d = mod_q ? step_hi : step_lo;
                        vout_d = 1'b0;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            cin_q   <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            cout_q  <= 1'b0;
            vout_q  <= 1'b0;
`ifdef ALU_SEQ_DIVIDE_EN
            mod_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            cin_q   <= cin_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            cout_q  <= cout_d;
            vout_q  <= vout_d;
`ifdef ALU_SEQ_DIVIDE_EN
            mod_q   <= mod_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32).
// DIV/MOD checks follow whether ALU_SEQ_DIVIDE_EN is defined.
module tb_alu_seq;

    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_CMP = 6'd2;
    localparam logic [5:0] OP_AND = 6'd3;
    localparam logic [5:0] OP_OR  = 6'd4;
    localparam logic [5:0] OP_XOR = 6'd5;
    localparam logic [5:0] OP_MOV = 6'd6;
    localparam logic [5:0] OP_ASL = 6'd7;
    localparam logic [5:0] OP_ASR = 6'd8;
    localparam logic [5:0] OP_LSR = 6'd9;
    localparam logic [5:0] OP_ROL = 6'd10;
    localparam logic [5:0] OP_ROR = 6'd11;
    localparam logic [5:0] OP_MUL = 6'd12;
    localparam logic [5:0] OP_DIV = 6'd13;
    localparam logic [5:0] OP_MOD = 6'd14;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] din_a;
    logic [31:0] din_b;
    logic        cin;
    logic        vin;
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic        cout;
    logic        vout;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .opcode (opcode),
        .din_a  (din_a),
        .din_b  (din_b),
        .cin    (cin),
        .vin    (vin),
        .busy   (busy),
        .done   (done),
        .dout   (dout),
        .cout   (cout),
        .vout   (vout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is high for exactly one rising edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic ci,
                         input logic vi);
        start  = 1'b1;
        opcode = op;
        din_a  = a;
        din_b  = b;
        cin    = ci;
        vin    = vi;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // n = 1 means done is high in the cycle right after the accept edge.
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic op1(input string tag, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic vi,
                       input logic [31:0] ed, input logic ec,
                       input logic ev);
        int n;
        issue(op, a, b, ci, vi);
        wait_done(n);
        chk({tag, "_lat"}, n, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_dout"}, dout, ed);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_vout"}, vout, ev);
    endtask

    initial begin
        int n;
        int pulses;
        reset  = 1'b1;
        start  = 1'b0;
        opcode = '0;
        din_a  = '0;
        din_b  = '0;
        cin    = 1'b0;
        vin    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dout", dout, 0);
        chk("rst_cout", cout, 0);
        chk("rst_vout", vout, 0);

        op1("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1);
        op1("add_cy",  OP_ADD, 32'hFFFF_FFFF, 32'h1, 0, 1, 32'h0, 1, 0);
        op1("sub_brw", OP_SUB, 32'h0, 32'h1, 0, 1, 32'hFFFF_FFFF, 1, 0);
        op1("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 0, 0, 32'h7FFF_FFFF, 0, 1);
        op1("cmp",     OP_CMP, 32'h5, 32'h3, 1, 0, 32'h2, 0, 0);
        op1("and",     OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 1, 1, 32'h0000_00F0, 0, 1);
        op1("or",      OP_OR,  32'h1200_0034, 32'h0056_7800, 1, 0, 32'h1256_7834, 0, 0);
        op1("xor",     OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 0, 32'hF0F0_0F0F, 0, 0);
        op1("mov",     OP_MOV, 32'hDEAD_0000, 32'h1234_5678, 1, 0, 32'h1234_5678, 1, 0);
        op1("ror",     OP_ROR, 32'h0000_0001, 32'h1, 0, 1, 32'h0, 1, 1);
        op1("rol",     OP_ROL, 32'h8000_0000, 32'h1, 0, 0, 32'h0, 1, 0);
        op1("rol_cin", OP_ROL, 32'h0000_0000, 32'h4, 1, 0, 32'h0000_0008, 0, 0);
        op1("asr",     OP_ASR, 32'h8000_0000, 32'd31, 0, 0, 32'hFFFF_FFFF, 0, 0);
        op1("asl",     OP_ASL, 32'hC000_0001, 32'h1, 0, 0, 32'h8000_0002, 1, 0);
        op1("lsr",     OP_LSR, 32'h0000_0003, 32'h1, 0, 1, 32'h0000_0001, 1, 1);
        op1("asl_z",   OP_ASL, 32'hDEAD_BEEF, 32'h20, 1, 0, 32'hDEAD_BEEF, 1, 0);
        op1("unk_op",  6'd63,  32'h1111_1111, 32'hCAFE_F00D, 0, 1, 32'hCAFE_F00D, 0, 1);

        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("dout_hold", dout, 32'hCAFE_F00D);

        // MUL timing: busy t+1..t+31, done at t+32
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0001, 1, 0);
        chk("mul_busy1", busy, 1);
        repeat (30) @(negedge clk);
        chk("mul_busy31", busy, 1);
        chk("mul_nodone31", done, 0);
        @(negedge clk);
        chk("mul_done32", done, 1);
        chk("mul_busy32", busy, 0);
        chk("mul_dout", dout, 32'h0001_0000);
        chk("mul_vout", vout, 1);
        chk("mul_cout", cout, 1);

        // back-to-back start issued in the done cycle
        issue(OP_MUL, 32'hFFFF_FFFF, 32'h2, 0, 0);
        wait_done(n);
        chk("b2b_lat", n, 32);
        chk("b2b_dout", dout, 32'hFFFF_FFFE);
        chk("b2b_vout", vout, 1);
        chk("b2b_cout", cout, 0);

        // start while busy with other operands must be ignored
        @(negedge clk);
        issue(OP_MUL, 32'h3, 32'h5, 0, 0);
        repeat (2) @(negedge clk);
        issue(OP_ADD, 32'h7, 32'h9, 1, 1);
        wait_done(n);
        chk("ign_lat", n, 29);
        chk("ign_dout", dout, 32'd15);
        chk("ign_vout", vout, 0);
        @(negedge clk);
        chk("ign_nodone", done, 0);

        // reset in cycle t+5 of a MUL
        issue(OP_MUL, 32'h1234, 32'h5678, 0, 0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_dout", dout, 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("mrst_nopulse", pulses, 0);
        op1("post_rst", OP_ADD, 32'h1, 32'h2, 0, 0, 32'h3, 0, 0);

`ifdef ALU_SEQ_DIVIDE_EN
        issue(OP_DIV, 32'd100, 32'd7, 1, 1);
        wait_done(n);
        chk("div_lat", n, 32);
        chk("div_dout", dout, 32'd14);
        chk("div_cout", cout, 1);
        chk("div_vout", vout, 0);
        issue(OP_MOD, 32'd100, 32'd7, 0, 1);
        wait_done(n);
        chk("mod_lat", n, 32);
        chk("mod_dout", dout, 32'd2);
        chk("mod_vout", vout, 0);
        @(negedge clk);
        op1("div0", OP_DIV, 32'd5, 32'd0, 0, 0, 32'hFFFF_FFFF, 0, 1);
        op1("mod0", OP_MOD, 32'd9, 32'd0, 1, 0, 32'd9, 1, 1);
`else
        op1("div_mov", OP_DIV, 32'd100, 32'd7, 1, 0, 32'd7, 1, 0);
        op1("mod_mov", OP_MOD, 32'd100, 32'd7, 0, 1, 32'd7, 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
